ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4, legal range 1..15: the maximum number of consecutive grants to one master while the other master is waiting.
REQ-002 CLK  in  1  system clock; all state updates on the rising edge.
REQ-003 RESET  in  1  asynchronous, active-high reset.
REQ-004 m0_rd, m0_wr  in  1  read / write request from master 0 (core data port).
REQ-005 m0_addr  in  32  byte address; m0_wdata  in  32  write data.
REQ-006 m0_gnt  out  1  master 0 access performed this cycle; m0_rvalid  out  1; m0_rdata  out  32.
REQ-007 m1_rd, m1_wr, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same widths and meaning as master 0, for master 1 (loader/debug port).
REQ-008 ram_address  out  10  word address, equal to addr[11:2] of the granted master.
REQ-009 ram_data  out  32  write data; ram_wren  out  1; ram_wread  out  1.
REQ-010 ram_salida  in  32  synchronous RAM read data, valid one cycle after ram_wread.
REQ-011 err  out  1  sticky protocol-error flag.

Function
REQ-012 A master is requesting when exactly one of rd/wr is high; rd&wr both high SHALL count as not requesting, and SHALL set err on the next edge.
REQ-013 Grants SHALL be combinational from the current state and requests; at most one gnt is high per cycle; gnt is never high without a valid request.
REQ-014 While mX_gnt is high: ram_address = mX_addr[11:2], ram_data = mX_wdata, ram_wren = mX_wr, ram_wread = mX_rd; with no grant all four are 0.
REQ-015 Read latency is 1 cycle: mX_rvalid SHALL pulse high exactly one cycle after a granted read, with mX_rdata = ram_salida; otherwise rvalid = 0 and rdata = 0.
REQ-016 Writes complete at the granting edge; there is no response for a write.
REQ-017 The FSM has three states: IDLE, OWN0 and OWN1, plus a burst counter cnt (4 bits).
REQ-018 IDLE, single requester X: grant X, go to OWNX, set cnt = 1.
REQ-019 IDLE, both requesting: the winner follows REQ-028/029, go to OWN(winner), set cnt = 1.
REQ-020 OWNX, X requesting and (cnt < MAX_BURST or other idle): grant X, stay; cnt increments and saturates at MAX_BURST.
REQ-021 OWNX, other requesting and (X idle or cnt == MAX_BURST): grant other, go to OWN(other), set cnt = 1.
REQ-022 OWNX, no requests: no grant, go to IDLE, set cnt = 0.
REQ-023 A master that is refused SHALL keep its request and signals stable; the arbiter does not latch requests.
REQ-024 addr[1:0] != 0 on a granted access SHALL set err; the access is still performed on the word.
REQ-025 addr[31:12] is ignored.

Reset
REQ-026 While RESET is high, and immediately on assertion: state = IDLE, cnt = 0, both rvalid = 0, both rdata = 0, err = 0, last-served = master 1.
REQ-027 A read granted in the cycle RESET asserts SHALL produce no rvalid.

Configuration
REQ-028 With ARB_RR_EN defined: a tie in IDLE goes to the master not served last; the last-served register updates on every grant.
REQ-029 With ARB_RR_EN undefined: a tie in IDLE always goes to master 0 and no last-served register exists; the burst limit applies in both builds.

Verification
REQ-030 m0 reads addr 0x10 alone after reset -> m0_gnt in the same cycle, ram_address = 0x004, m0_rvalid with stored data in the next cycle.
REQ-031 m1 writes 0xCAFEF00D to 0x20, then m0 reads 0x20 -> m0_rdata = 0xCAFEF00D one cycle after the m0 grant.
REQ-032 Both request continuously from IDLE, MAX_BURST = 4 -> grant pattern 4×m0, 4×m1, 4×m0 (build without ARB_RR_EN), or starting with m0 (build with ARB_RR_EN, since last-served resets to master 1).
REQ-033 m0_rd and m0_wr both high for one cycle -> no grant, err = 1 next cycle and stays 1 until RESET; an m0_addr with addr[1:0] = 2'b10 on a granted access also sets err.
REQ-034 RESET asserted mid-burst in OWN1 with a read in flight -> all outputs 0 at once, no rvalid, a fresh request after release is granted from IDLE.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of a single-port synchronous RAM, with a per-owner burst limit.
// Define ARB_RR_EN to break IDLE ties in favour of the master not served last (default: master 0 wins).
module ram_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        m0_rd,
    input  logic        m0_wr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_rd,
    input  logic        m1_wr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic [9:0]  ram_address,
    output logic [31:0] ram_data,
    output logic        ram_wren,
    output logic        ram_wread,
    input  logic [31:0] ram_salida,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rvalid0_q, rvalid0_d;
    logic        rvalid1_q, rvalid1_d;
    logic        err_q, err_d;
    logic        req0, req1;
    logic        gnt0, gnt1;
    logic        tie_to_m1;
    logic        unused_addr_bits;

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c < BURST_MAX) ? c + 4'd1 : c;
    endfunction

    // rd and wr together is a protocol error, not a request
    assign req0 = m0_rd ^ m0_wr;
    assign req1 = m1_rd ^ m1_wr;

`ifdef ARB_RR_EN
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign tie_to_m1 = ~last_q;
`else
    assign tie_to_m1 = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        if (gnt0) begin
            state_d = OWN0;
            cnt_d   = (state_q == OWN0) ? sat_inc(cnt_q) : 4'd1;
        end else if (gnt1) begin
            state_d = OWN1;
            cnt_d   = (state_q == OWN1) ? sat_inc(cnt_q) : 4'd1;
        end
    end

    // Grants are forced low while RESET is held so the RAM sees no access
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!RESET) begin
            case (state_q)
                OWN0: begin
                    if (req0 && (cnt_q < BURST_MAX || !req1)) begin
                        gnt0 = 1'b1;
                    end else if (req1) begin
                        gnt1 = 1'b1;
                    end
                end
                OWN1: begin
                    if (req1 && (cnt_q < BURST_MAX || !req0)) begin
                        gnt1 = 1'b1;
                    end else if (req0) begin
                        gnt0 = 1'b1;
                    end
                end
                default: begin
                    if (req0 && req1) begin
                        gnt1 = tie_to_m1;
                        gnt0 = ~tie_to_m1;
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        ram_address = 10'd0;
        ram_data    = 32'd0;
        ram_wren    = 1'b0;
        ram_wread   = 1'b0;
        if (gnt0) begin
            ram_address = m0_addr[11:2];
            ram_data    = m0_wdata;
            ram_wren    = m0_wr;
            ram_wread   = m0_rd;
        end else if (gnt1) begin
            ram_address = m1_addr[11:2];
            ram_data    = m1_wdata;
            ram_wren    = m1_wr;
            ram_wread   = m1_rd;
        end
    end

    always_comb begin
        rvalid0_d = gnt0 & m0_rd;
        rvalid1_d = gnt1 & m1_rd;
        err_d     = err_q
                  | (m0_rd & m0_wr)
                  | (m1_rd & m1_wr)
                  | (gnt0 & (m0_addr[1:0] != 2'b00))
                  | (gnt1 & (m1_addr[1:0] != 2'b00));
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            err_q     <= err_d;
        end
    end

    // The RAM returns data one cycle after the granted read; route it only to the reader
    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign m0_rvalid = rvalid0_q;
    assign m1_rvalid = rvalid1_q;
    assign m0_rdata  = rvalid0_q ? ram_salida : 32'd0;
    assign m1_rdata  = rvalid1_q ? ram_salida : 32'd0;
    assign err       = err_q;

    assign unused_addr_bits = ^{m0_addr[31:12], m1_addr[31:12]};

endmodule
